// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Groups the serial line, frame configuration and receive result signals of
// the UART receiver into one bundle.
//
// Signals
//   RX_IN       serial line, idle high (driven by the line / transmitter side)
//   PAR_EN      1 = frame carries a parity bit
//   PAR_TYP     0 = even parity, 1 = odd parity
//   PRESCALE    oversampling clocks per bit (even, 8..2**PRESCALE_W-2)
//   P_DATA      last good received word
//   DATA_VALID  1-cycle strobe, P_DATA updated with a good frame
//   PAR_ERR     1-cycle strobe, parity mismatch, frame dropped
//   STP_ERR     1-cycle strobe, stop bit sampled low, frame dropped
//
// Modports
//   master  side that drives the line and configuration, consumes results
//   slave   the receiver core
// -----------------------------------------------------------------------------
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN,
        output PAR_EN,
        output PAR_TYP,
        output PRESCALE,
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_ERR,
        input  STP_ERR
    );

    modport slave (
        input  RX_IN,
        input  PAR_EN,
        input  PAR_TYP,
        input  PRESCALE,
        output P_DATA,
        output DATA_VALID,
        output PAR_ERR,
        output STP_ERR
    );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial-to-parallel UART receiver. Oversamples RX_IN at PRESCALE clocks per
// bit and accepts 1 start bit, DATA_WIDTH data bits (LSB first), an optional
// parity bit and 1 stop bit. A good frame updates P_DATA with a one-cycle
// DATA_VALID strobe; a bad frame is dropped with a one-cycle PAR_ERR or
// STP_ERR strobe (STP_ERR wins when both apply).
//
// Ports
//   CLK   oversampling clock (PRESCALE x bit rate)
//   RST   asynchronous, active-low reset
//   bus   uart_rx_core_if.slave: RX_IN, PAR_EN, PAR_TYP, PRESCALE in;
//         P_DATA, DATA_VALID, PAR_ERR, STP_ERR out (all outputs registered)
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every bit is the majority of the
//                        samples at edge PRESCALE/2-1, /2, /2+1 (decided at
//                        /2+1). When undefined, one sample at PRESCALE/2.
//                        Frame and strobe timing are the same in both builds.
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_core_if.slave bus
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 vote used to reject single-cycle glitches around the sample point.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Synchroniser and its fill tracker: the flops reset to 1, so the first
    // two post-reset values of rx_s are not real line samples.
    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_sync_q, rx_sync_d;
    logic [1:0]            sync_fill_q, sync_fill_d;
    logic                  rx_s;

    // Frame control
    state_e                state_q, state_d;
    logic                  armed_q, armed_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;

    // Configuration frozen at start detection
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    // Datapath
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  bit_val_q, bit_val_d;
    logic                  par_bad_q, par_bad_d;
`ifdef UART_RX_MAJORITY_EN
    logic [1:0]            samp_q, samp_d;
`endif

    // Registered outputs
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    // Bit timing helpers derived from the frozen prescale value
    logic [PRESCALE_W-1:0] half_s;
    logic [PRESCALE_W-1:0] last_s;
    logic                  bit_end_s;

    assign rx_s      = rx_sync_q;
    assign half_s    = {1'b0, prescale_q[PRESCALE_W-1:1]};
    assign last_s    = prescale_q - {{(PRESCALE_W-1){1'b0}}, 1'b1};
    assign bit_end_s = (edge_cnt_q == last_s);

    // Synchroniser next-state: shift the line in, and count two fills.
    always_comb begin
        rx_meta_d   = bus.RX_IN;
        rx_sync_d   = rx_meta_q;
        sync_fill_d = {sync_fill_q[0], 1'b1};
    end

    // Bit sampling: latch the value of the current bit before its end.
    always_comb begin
        bit_val_d = bit_val_q;
`ifdef UART_RX_MAJORITY_EN
        samp_d = samp_q;
        if (state_q == ST_IDLE) begin
            samp_d = samp_q;
        end else if (edge_cnt_q == (half_s - {{(PRESCALE_W-1){1'b0}}, 1'b1})) begin
            samp_d[0] = rx_s;
        end else if (edge_cnt_q == half_s) begin
            samp_d[1] = rx_s;
        end else if (edge_cnt_q == (half_s + {{(PRESCALE_W-1){1'b0}}, 1'b1})) begin
            bit_val_d = maj3(samp_q[0], samp_q[1], rx_s);
        end else begin
            bit_val_d = bit_val_q;
        end
`else
        if ((state_q != ST_IDLE) && (edge_cnt_q == half_s)) begin
            bit_val_d = rx_s;
        end else begin
            bit_val_d = bit_val_q;
        end
`endif
    end

    // Frame FSM next-state, counters, datapath and output strobes.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        prescale_d   = prescale_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        // Arm only on a genuine idle-high sample seen while waiting.
        if ((state_q == ST_IDLE) && sync_fill_q[1] && rx_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        // Edge counter runs over 0..PRESCALE-1 inside a frame, held at 0 in IDLE.
        if (state_q == ST_IDLE) begin
            edge_cnt_d = '0;
        end else if (bit_end_s) begin
            edge_cnt_d = '0;
        end else begin
            edge_cnt_d = edge_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rx_s) begin
                    // The detect cycle is edge 0 of the start bit, so the
                    // counter moves on to 1; this keeps back-to-back frames
                    // free of any per-frame cycle drift.
                    state_d    = ST_START;
                    edge_cnt_d = {{(PRESCALE_W-1){1'b0}}, 1'b1};
                    bit_cnt_d  = '0;
                    par_en_d   = bus.PAR_EN;
                    par_typ_d  = bus.PAR_TYP;
                    prescale_d = bus.PRESCALE;
                    par_bad_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (bit_end_s) begin
                    // A start bit that reads high at the sample point is a glitch.
                    if (bit_val_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end

            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d = {bit_val_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_PARITY: begin
                if (bit_end_s) begin
                    par_bad_d = bit_val_q ^ (^shift_q) ^ par_typ_q;
                    state_d   = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end

            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    if (!bit_val_q) begin
                        // Low stop bit: possibly a break, so wait for the
                        // line to return high before accepting a new start.
                        stp_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end else if (par_bad_q) begin
                        par_err_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            sync_fill_q  <= 2'b00;
            state_q      <= ST_IDLE;
            armed_q      <= 1'b0;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            prescale_q   <= '0;
            shift_q      <= '0;
            bit_val_q    <= 1'b0;
            par_bad_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            samp_q       <= 2'b00;
`endif
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            sync_fill_q  <= sync_fill_d;
            state_q      <= state_d;
            armed_q      <= armed_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            prescale_q   <= prescale_d;
            shift_q      <= shift_d;
            bit_val_q    <= bit_val_d;
            par_bad_q    <= par_bad_d;
`ifdef UART_RX_MAJORITY_EN
            samp_q       <= samp_d;
`endif
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core. Drives the serial line on falling clock
// edges and checks outputs on falling edges. A strobe monitor counts every
// DATA_VALID / PAR_ERR / STP_ERR pulse and records DATA_VALID timing/data.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int DW = 8;
    localparam int PW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_core_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

    uart_rx_core #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int        cyc    = 0;
    int        n_dv   = 0;
    int        n_pe   = 0;
    int        n_se   = 0;
    int        dv_t0  = 0;
    int        dv_t1  = 0;
    logic [7:0] dv_d0 = 8'h00;
    logic [7:0] dv_d1 = 8'h00;

    logic [2:0] strb;
    assign strb = {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR};

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.DATA_VALID) begin
            n_dv  = n_dv + 1;
            dv_t0 = dv_t1;
            dv_t1 = cyc;
            dv_d0 = dv_d1;
            dv_d1 = bus.P_DATA;
        end
        if (bus.PAR_ERR) n_pe = n_pe + 1;
        if (bus.STP_ERR) n_se = n_se + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp)
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus.RX_IN = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame; glitch_bit >= 0 puts a 1-cycle low pulse at the sample
    // point of that data bit (only when the bit is 1). The stop level stays
    // on the line when the task returns.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit, input int p, input int glitch_bit);
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if ((i == glitch_bit) && d[i]) begin
                drive(1'b1, p / 2);
                drive(1'b0, 1);
                drive(1'b1, p / 2 - 1);
            end else begin
                drive(d[i], p);
            end
        end
        if (pen) drive(pbit, p);
        drive(sbit, p);
    endtask

    // Result window right after a frame: nothing on the first cycle, the
    // expected strobe on the second, nothing on the third.
    task automatic post_check(input string tag, input logic [2:0] exp_strb, input logic [7:0] exp_data);
        @(negedge clk);
        check({tag, " pre"}, 32'(strb), 32'd0);
        @(negedge clk);
        check({tag, " strobe"}, 32'(strb), 32'(exp_strb));
        check({tag, " p_data"}, 32'(bus.P_DATA), 32'(exp_data));
        @(negedge clk);
        check({tag, " post"}, 32'(strb), 32'd0);
    endtask

    initial begin
        bus.RX_IN    = 1'b1;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.PRESCALE = 6'd8;
        repeat (3) @(negedge clk);
        check("reset p_data", 32'(bus.P_DATA), 32'd0);
        check("reset strobes", 32'(strb), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 10);

        // 1: 0x2A has three ones, even parity bit 1, good frame.
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b0;
        send_frame(8'h2A, 1'b1, 1'b1, 1'b1, 8, -1);
        bus.RX_IN = 1'b1;
        post_check("t1", 3'b100, 8'h2A);
        drive(1'b1, 10);

        // 2: 0x59 has four ones, odd parity needs 1; send 0 to force the error.
        bus.PAR_TYP = 1'b1;
        send_frame(8'h59, 1'b1, 1'b0, 1'b1, 8, -1);
        bus.RX_IN = 1'b1;
        post_check("t2", 3'b010, 8'h2A);
        drive(1'b1, 10);

        // 3: stop bit low, then line held low (break) for a long while.
        bus.PAR_EN   = 1'b0;
        bus.PRESCALE = 6'd16;
        send_frame(8'h42, 1'b0, 1'b0, 1'b0, 16, -1);
        bus.RX_IN = 1'b0;
        post_check("t3", 3'b001, 8'h2A);
        drive(1'b0, 200);
        #1;
        check("t3 break stp count", 32'(n_se), 32'd1);
        check("t3 break dv count", 32'(n_dv), 32'd1);
        drive(1'b1, 20);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, -1);
        bus.RX_IN = 1'b1;
        post_check("t3 recover", 3'b100, 8'h3C);
        drive(1'b1, 10);

        // 4: 2-cycle low glitch is not a start bit.
        bus.PRESCALE = 6'd8;
        drive(1'b0, 2);
        drive(1'b1, 30);
        #1;
        check("t4 glitch dv count", 32'(n_dv), 32'd2);
        check("t4 glitch err count", 32'({n_pe[15:0], n_se[15:0]}), 32'h0001_0001);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, -1);
        bus.RX_IN = 1'b1;
        post_check("t4", 3'b100, 8'hA5);
        drive(1'b1, 10);

        // 5: back-to-back frames, no idle gap.
        bus.PRESCALE = 6'd16;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 16, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 16, -1);
        drive(1'b1, 5);
        #1;
        check("t5 dv count", 32'(n_dv), 32'd5);
        check("t5 spacing", 32'(dv_t1 - dv_t0), 32'd160);
        check("t5 first word", 32'(dv_d0), 32'h42);
        check("t5 second word", 32'(dv_d1), 32'hFF);

        // 6: reset during data bit 3, release with the line low.
        bus.PRESCALE = 6'd8;
        drive(1'b0, 8);
        drive(1'b1, 8);
        drive(1'b0, 8);
        drive(1'b0, 8);
        drive(1'b1, 4);
        rst_n = 1'b0;
        bus.RX_IN = 1'b0;
        #1;
        check("t6 reset p_data", 32'(bus.P_DATA), 32'd0);
        check("t6 reset strobes", 32'(strb), 32'd0);
        drive(1'b0, 5);
        rst_n = 1'b1;
        drive(1'b0, 200);
        #1;
        check("t6 no strobes", 32'(n_dv + n_pe + n_se), 32'd7);
        drive(1'b1, 20);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8, -1);
        bus.RX_IN = 1'b1;
        post_check("t6", 3'b100, 8'h81);
        drive(1'b1, 10);

`ifdef UART_RX_MAJORITY_EN
        // 0xB7 bit 2 is 1; a 1-cycle low at its sample point is voted out.
        send_frame(8'hB7, 1'b0, 1'b0, 1'b1, 8, 2);
        bus.RX_IN = 1'b1;
        post_check("t6 majority", 3'b100, 8'hB7);
        drive(1'b1, 10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
